batch_scheduler_param: RTL and testbench

- Parametrised successor to the batch scheduler. Accepts a stream of decoded requests, groups them per bank into distinct-row slots, and closes a batch on size, row-slot exhaustion or external request.
- After close, scans all banks and reports the critical bank: the one with the most requests in the batch, plus its row count.
- Tables are internal registers, so no external SRR/SBR memories are needed. Sits between request decode and the command issuer.

---
 rtl/batch_scheduler_param.sv | 220 ++++++++++++++++++++++
 tb/tb_batch_scheduler_param.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/batch_scheduler_param.sv
// batch_scheduler_param
//
// Groups decoded requests into per-bank distinct-row slots and closes a batch
// on size, row-slot exhaustion or an external close. It then scans all banks
// and reports the critical bank, which is the one with the most requests in
// the batch. All tables are internal registers.
//
// Optional feature: define BATCH_TIMEOUT_EN to close a partial batch after
// TIMEOUT cycles in COLLECT. When the macro is undefined, a partial batch
// waits indefinitely.
//
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   req_valid     request present
//   req_ready     request accepted when req_valid & req_ready
//   req_bank      target bank of the request
//   req_row       target row of the request
//   batch_close   force close of the current non-empty batch
//   busy          high while scanning (SCAN) and reporting (DONE)
//   batch_done    one-cycle pulse; crit_* are valid
//   crit_bank     critical bank of the last closed batch
//   crit_total    requests to crit_bank
//   crit_rows     distinct rows in crit_bank
//   batch_count   requests in the current (or last closed) batch
module batch_scheduler_param #(
    parameter int BANK_ID_W     = 4,
    parameter int ROW_W         = 16,
    parameter int ROWS_PER_BANK = 4,
    parameter int CNT_W         = 8,
    parameter int BATCH_MAX     = 32,
    parameter int TIMEOUT       = 64
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 req_valid,
    output logic                                 req_ready,
    input  logic [BANK_ID_W-1:0]                 req_bank,
    input  logic [ROW_W-1:0]                     req_row,
    input  logic                                 batch_close,
    output logic                                 busy,
    output logic                                 batch_done,
    output logic [BANK_ID_W-1:0]                 crit_bank,
    output logic [CNT_W-1:0]                     crit_total,
    output logic [$clog2(ROWS_PER_BANK+1)-1:0]   crit_rows,
    output logic [CNT_W-1:0]                     batch_count
);
    localparam int NUM_BANKS = 2 ** BANK_ID_W;
    localparam int RC_W      = $clog2(ROWS_PER_BANK + 1);
    localparam int SLOT_W    = (ROWS_PER_BANK > 1) ? $clog2(ROWS_PER_BANK) : 1;

    typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_SCAN, S_DONE} state_t;
    state_t state, state_next;

    // Per-bank slot tables and per-bank summaries.
    logic [NUM_BANKS-1:0][ROWS_PER_BANK-1:0]            slot_valid;
    logic [NUM_BANKS-1:0][ROWS_PER_BANK-1:0][ROW_W-1:0] slot_tag;
    logic [NUM_BANKS-1:0][ROWS_PER_BANK-1:0][CNT_W-1:0] slot_cnt;
    logic [NUM_BANKS-1:0][CNT_W-1:0]                    bank_total;
    logic [NUM_BANKS-1:0][RC_W-1:0]                     bank_rows;

    // Per-row hit counts have no output port; the reduction below only keeps
    // them from being reported as dangling.
    logic unused_slot_cnt;
    assign unused_slot_cnt = ^slot_cnt;

    // Row lookup in the addressed bank.
    logic              row_hit, has_free;
    logic [SLOT_W-1:0] hit_slot, free_slot;

    // NOTE: every signal in an always_comb gets a default first; otherwise a
    // path that skips the assignment infers a latch.
    always_comb begin
        row_hit   = 1'b0;
        has_free  = 1'b0;
        hit_slot  = '0;
        free_slot = '0;
        // Walking downward leaves the lowest-index free slot as the final assignment.
        for (int s = ROWS_PER_BANK - 1; s >= 0; s--) begin
            if (slot_valid[req_bank][s] && slot_tag[req_bank][s] == req_row) begin
                row_hit  = 1'b1;
                hit_slot = SLOT_W'(s);
            end
            if (!slot_valid[req_bank][s]) begin
                has_free  = 1'b1;
                free_slot = SLOT_W'(s);
            end
        end
    end

    logic open_state, slot_block, accept, size_close, collect_close, timeout_close;
    logic [BANK_ID_W-1:0] scan_idx;
    logic                 scan_last;

    assign open_state = (state == S_IDLE) || (state == S_COLLECT);
    // A pending miss with no free slot cannot join this batch. It is held
    // back and becomes the first request of the next batch.
    assign slot_block = req_valid && !row_hit && !has_free;
    assign accept     = req_valid && req_ready;
    assign size_close = accept && (batch_count == CNT_W'(BATCH_MAX - 1));
    assign collect_close = (state == S_COLLECT) &&
                           (size_close || batch_close || slot_block || timeout_close);
    assign scan_last  = (scan_idx == BANK_ID_W'(NUM_BANKS - 1));

`ifdef BATCH_TIMEOUT_EN
    localparam int AGE_W = $clog2(TIMEOUT + 1);
    logic [AGE_W-1:0] age;

    // Age is 0 after the accepting edge out of IDLE and counts COLLECT cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            age <= '0;
        end else if (state == S_COLLECT) begin
            age <= age + 1'b1;
        end else begin
            age <= '0;
        end
    end
    assign timeout_close = (state == S_COLLECT) && (age == AGE_W'(TIMEOUT - 1));
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT > 0);
    assign timeout_close  = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    // Next-state logic. Size close also applies to an accept in IDLE, so a
    // BATCH_MAX of 1 can never overrun the batch.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:    if (accept) state_next = size_close ? S_SCAN : S_COLLECT;
            S_COLLECT: if (collect_close) state_next = S_SCAN;
            S_SCAN:    if (scan_last) state_next = S_DONE;
            S_DONE:    state_next = S_IDLE;
            default:   state_next = S_IDLE;
        endcase
    end

    // Output logic.
    always_comb begin
        req_ready  = open_state && !rst && !slot_block;
        busy       = (state == S_SCAN) || (state == S_DONE);
        batch_done = (state == S_DONE);
    end

    // Table and batch-count updates.
    // NOTE: the tables are flops, so they are cleared by reset as well as at
    // the end of DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_valid  <= '0;
            slot_tag    <= '0;
            slot_cnt    <= '0;
            bank_total  <= '0;
            bank_rows   <= '0;
            batch_count <= '0;
        end else if (state == S_DONE) begin
            slot_valid  <= '0;
            slot_tag    <= '0;
            slot_cnt    <= '0;
            bank_total  <= '0;
            bank_rows   <= '0;
            batch_count <= '0;
        end else if (accept) begin
            batch_count          <= batch_count + 1'b1;
            bank_total[req_bank] <= bank_total[req_bank] + 1'b1;
            if (row_hit) begin
                slot_cnt[req_bank][hit_slot] <= slot_cnt[req_bank][hit_slot] + 1'b1;
            end else begin
                slot_valid[req_bank][free_slot] <= 1'b1;
                slot_tag[req_bank][free_slot]   <= req_row;
                slot_cnt[req_bank][free_slot]   <= CNT_W'(1);
                bank_rows[req_bank]             <= bank_rows[req_bank] + 1'b1;
            end
        end
    end

    // Scan. A bank replaces the running max only on a strictly greater total,
    // so ties go to the lowest index. Bank 0 seeds the max.
    logic [BANK_ID_W-1:0] max_bank;
    logic [CNT_W-1:0]     max_total;
    logic [RC_W-1:0]      max_rows;
    logic                 cand_take;

    assign cand_take = (scan_idx == '0) || (bank_total[scan_idx] > max_total);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scan_idx   <= '0;
            max_bank   <= '0;
            max_total  <= '0;
            max_rows   <= '0;
            crit_bank  <= '0;
            crit_total <= '0;
            crit_rows  <= '0;
        end else if (state == S_SCAN) begin
            // The index is exactly BANK_ID_W wide, so it wraps back to 0 on
            // the last bank.
            scan_idx <= scan_idx + 1'b1;
            if (cand_take) begin
                max_bank  <= scan_idx;
                max_total <= bank_total[scan_idx];
                max_rows  <= bank_rows[scan_idx];
            end
            if (scan_last) begin
                crit_bank  <= cand_take ? scan_idx             : max_bank;
                crit_total <= cand_take ? bank_total[scan_idx] : max_total;
                crit_rows  <= cand_take ? bank_rows[scan_idx]  : max_rows;
            end
        end else begin
            scan_idx <= '0;
        end
    end

endmodule

// File: tb/tb_batch_scheduler_param.sv
// Directed testbench for batch_scheduler_param with default parameters
// (16 banks, 4 row slots per bank, BATCH_MAX 32). Inputs are driven on the
// falling edge and outputs are sampled on the falling edge or 1 ns after it.
module tb_batch_scheduler_param;
    logic        clk, rst;
    logic        req_valid, req_ready, batch_close, busy, batch_done;
    logic [3:0]  req_bank, crit_bank;
    logic [15:0] req_row;
    logic [7:0]  crit_total, batch_count;
    logic [2:0]  crit_rows;

    int checks   = 0;
    int failures = 0;

    batch_scheduler_param dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_bank(req_bank), .req_row(req_row),
        .batch_close(batch_close),
        .busy(busy), .batch_done(batch_done),
        .crit_bank(crit_bank), .crit_total(crit_total),
        .crit_rows(crit_rows), .batch_count(batch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish within its time limit");
        $fatal(1);
    end

    // Presents one request at a falling edge and expects it to be accepted
    // at the next rising edge. The task returns on the following falling edge.
    task automatic send(input logic [3:0] b, input logic [15:0] r, input logic cl, input string tag);
        req_valid = 1'b1; req_bank = b; req_row = r; batch_close = cl;
        #1;
        checks++;
        if (req_ready !== 1'b1) begin
            failures++; $display("FAIL %s_ready: got %b want 1", tag, req_ready);
        end
        @(negedge clk);
        req_valid = 1'b0; batch_close = 1'b0;
    endtask

    task automatic pulse_close();
        batch_close = 1'b1;
        @(negedge clk);
        batch_close = 1'b0;
    endtask

    // Counts falling edges until batch_done is seen, within a cycle budget.
    task automatic wait_done(input int budget, output int cycles, output bit seen);
        cycles = 0;
        while (batch_done !== 1'b1 && cycles < budget) begin
            @(negedge clk);
            cycles++;
        end
        seen = (batch_done === 1'b1);
    endtask

    task automatic test_reset();
        int cyc; bit seen;
        rst = 1'b1; req_valid = 1'b1; req_bank = 4'd0; req_row = 16'h0; batch_close = 1'b0;
        @(negedge clk);
        checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL rst_ready: got %b want 0", req_ready); end
        checks++; if ({busy, batch_done} !== 2'b00) begin failures++; $display("FAIL rst_busy_done: got %b want 00", {busy, batch_done}); end
        checks++; if ({crit_bank, crit_total, crit_rows, batch_count} !== '0) begin
            failures++; $display("FAIL rst_outputs: got bank=%0d total=%0d rows=%0d count=%0d want all 0",
                                 crit_bank, crit_total, crit_rows, batch_count);
        end
        req_valid = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        // A close in the same cycle as the first accept, while in IDLE, is ignored.
        send(4'd0, 16'h0001, 1'b1, "rst_first");
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_idle_close_ignored: busy got %b want 0", busy); end
        checks++; if (batch_count !== 8'd1) begin failures++; $display("FAIL rst_count: got %0d want 1", batch_count); end
        pulse_close();
        wait_done(40, cyc, seen);
        checks++; if (!seen) begin failures++; $display("FAIL rst_done: got timeout want batch_done"); end
        checks++; if ({crit_bank, crit_total, crit_rows} !== {4'd0, 8'd1, 3'd1}) begin
            failures++; $display("FAIL rst_crit: got bank=%0d total=%0d rows=%0d want 0/1/1", crit_bank, crit_total, crit_rows);
        end
        @(negedge clk);
    endtask

    task automatic test_size_close();
        int cyc; bit seen;
        // Request i goes to bank i%4. Rows alternate 0x10/0x20 on each visit to a bank.
        for (int i = 0; i < 32; i++)
            send(4'(i % 4), ((i / 4) % 2 == 0) ? 16'h0010 : 16'h0020, 1'b0, "size");
        checks++; if (batch_count !== 8'd32) begin failures++; $display("FAIL size_count: got %0d want 32", batch_count); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL size_scan_entered: busy got %b want 1", busy); end
        // SCAN runs from the 32nd accept edge for 16 cycles. DONE is the 17th
        // cycle, counting the SCAN cycle that starts at that edge, which puts
        // it 16 falling edges after this point.
        wait_done(40, cyc, seen);
        checks++; if (!seen || cyc != 16) begin failures++; $display("FAIL size_latency: got %0d (seen=%0d) want 16", cyc, seen); end
        checks++; if ({crit_bank, crit_total, crit_rows} !== {4'd0, 8'd8, 3'd2}) begin
            failures++; $display("FAIL size_crit: got bank=%0d total=%0d rows=%0d want 0/8/2", crit_bank, crit_total, crit_rows);
        end
        @(negedge clk);
        checks++; if ({batch_done, busy} !== 2'b00) begin failures++; $display("FAIL size_pulse: got done/busy=%b want 00", {batch_done, busy}); end
        checks++; if (batch_count !== 8'd0) begin failures++; $display("FAIL size_count_idle: got %0d want 0", batch_count); end
    endtask

    task automatic test_slot_exhaust();
        int cyc; bit seen;
        for (int r = 1; r <= 4; r++) send(4'd5, 16'(r), 1'b0, "exh_fill");
        req_valid = 1'b1; req_bank = 4'd5; req_row = 16'h0009;
        #1;
        checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL exh_blocked: ready got %b want 0", req_ready); end
        wait_done(40, cyc, seen);
        checks++; if (!seen || cyc != 17) begin failures++; $display("FAIL exh_latency: got %0d (seen=%0d) want 17", cyc, seen); end
        checks++; if ({crit_bank, crit_total, crit_rows} !== {4'd5, 8'd4, 3'd4}) begin
            failures++; $display("FAIL exh_crit: got bank=%0d total=%0d rows=%0d want 5/4/4", crit_bank, crit_total, crit_rows);
        end
        checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL exh_ready_done: got %b want 0", req_ready); end
        @(negedge clk);
        checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL exh_ready_idle: got %b want 1", req_ready); end
        @(negedge clk);
        req_valid = 1'b0;
        checks++; if (batch_count !== 8'd1 || busy !== 1'b0) begin
            failures++; $display("FAIL exh_pending_accept: got count=%0d busy=%b want 1/0", batch_count, busy);
        end
        pulse_close();
        wait_done(40, cyc, seen);
        checks++; if (!seen || {crit_bank, crit_total, crit_rows} !== {4'd5, 8'd1, 3'd1}) begin
            failures++; $display("FAIL exh_next_batch: got bank=%0d total=%0d rows=%0d want 5/1/1", crit_bank, crit_total, crit_rows);
        end
        @(negedge clk);
    endtask

    task automatic test_forced_close();
        int cyc; bit seen; bit stray;
        for (int i = 0; i < 3; i++) send(4'd2, 16'h0007, 1'b0, "force");
        send(4'd2, 16'h0007, 1'b1, "force_last");
        wait_done(40, cyc, seen);
        checks++; if (!seen || cyc != 16) begin failures++; $display("FAIL force_latency: got %0d (seen=%0d) want 16", cyc, seen); end
        checks++; if ({crit_bank, crit_total, crit_rows} !== {4'd2, 8'd4, 3'd1}) begin
            failures++; $display("FAIL force_crit: got bank=%0d total=%0d rows=%0d want 2/4/1", crit_bank, crit_total, crit_rows);
        end
        checks++; if (batch_count !== 8'd4) begin failures++; $display("FAIL force_count: got %0d want 4", batch_count); end
        @(negedge clk);
        pulse_close();
        stray = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (batch_done !== 1'b0 || busy !== 1'b0) stray = 1'b1;
            @(negedge clk);
        end
        checks++; if (stray) begin failures++; $display("FAIL force_idle_close: got activity want none"); end
    endtask

    task automatic test_row_hits();
        int cyc; bit seen;
        for (int i = 0; i < 10; i++) send(4'd1, 16'hABCD, 1'b0, "hits_b1");
        for (int i = 0; i < 2; i++)  send(4'd3, 16'h0001, 1'b0, "hits_b3");
        pulse_close();
        wait_done(40, cyc, seen);
        checks++; if (!seen) begin failures++; $display("FAIL hits_done: got timeout want batch_done"); end
        checks++; if (batch_count !== 8'd12) begin failures++; $display("FAIL hits_count: got %0d want 12", batch_count); end
        checks++; if ({crit_bank, crit_total, crit_rows} !== {4'd1, 8'd10, 3'd1}) begin
            failures++; $display("FAIL hits_crit: got bank=%0d total=%0d rows=%0d want 1/10/1", crit_bank, crit_total, crit_rows);
        end
        @(negedge clk);
    endtask

    task automatic test_idle_timeout();
        int cyc; bit seen;
        send(4'd7, 16'h0003, 1'b0, "tmo");
`ifdef BATCH_TIMEOUT_EN
        cyc = 0;
        while (busy !== 1'b1 && cyc < 200) begin @(negedge clk); cyc++; end
        checks++; if (cyc != 64) begin failures++; $display("FAIL tmo_scan_entry: got %0d want 64", cyc); end
`else
        seen = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            if (batch_done !== 1'b0 || busy !== 1'b0) seen = 1'b1;
            @(negedge clk);
        end
        checks++; if (seen) begin failures++; $display("FAIL tmo_no_close: got close want none"); end
        pulse_close();
`endif
        wait_done(200, cyc, seen);
        checks++; if (!seen || {crit_bank, crit_total, crit_rows} !== {4'd7, 8'd1, 3'd1}) begin
            failures++; $display("FAIL tmo_crit: got bank=%0d total=%0d rows=%0d want 7/1/1", crit_bank, crit_total, crit_rows);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_scan();
        int cyc; bit seen;
        send(4'd9, 16'h0001, 1'b0, "mid");
        send(4'd9, 16'h0002, 1'b1, "mid_close");
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL mid_in_scan: busy got %b want 1", busy); end
        #2;
        rst = 1'b1; req_valid = 1'b1; req_bank = 4'd0; req_row = 16'h0;
        #1;
        checks++; if ({req_ready, busy, batch_done} !== 3'b000) begin
            failures++; $display("FAIL mid_rst_ctrl: got ready/busy/done=%b want 000", {req_ready, busy, batch_done});
        end
        checks++; if ({crit_bank, crit_total, crit_rows, batch_count} !== '0) begin
            failures++; $display("FAIL mid_rst_outputs: got bank=%0d total=%0d rows=%0d count=%0d want all 0",
                                 crit_bank, crit_total, crit_rows, batch_count);
        end
        @(negedge clk);
        rst = 1'b0; req_valid = 1'b0;
        wait_done(40, cyc, seen);
        checks++; if (seen) begin failures++; $display("FAIL mid_aborted: got batch_done want none"); end
        send(4'd9, 16'h0005, 1'b0, "mid_post");
        checks++; if (batch_count !== 8'd1) begin failures++; $display("FAIL mid_post_count: got %0d want 1", batch_count); end
        pulse_close();
        wait_done(40, cyc, seen);
        checks++; if (!seen || {crit_bank, crit_total, crit_rows} !== {4'd9, 8'd1, 3'd1}) begin
            failures++; $display("FAIL mid_post_crit: got bank=%0d total=%0d rows=%0d want 9/1/1", crit_bank, crit_total, crit_rows);
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_size_close();
        test_slot_exhaust();
        test_forced_close();
        test_row_hits();
        test_idle_timeout();
        test_reset_mid_scan();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
